// File: rtl/serial_word_collector_if.sv
// Bundle of the serial collector's control, serial input and parallel output signals.
// The master side drives start/dir/en/sin/out_ready/clr_ovr; the slave side (the collector) drives the rest.
interface serial_word_collector_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic             dir;
  logic             en;
  logic             sin;
  logic             out_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] outdata;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  modport master (
    output start, dir, en, sin, out_ready, clr_ovr,
    input  outdata, out_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  start, dir, en, sin, out_ready, clr_ovr,
    output outdata, out_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/serial_word_collector.sv
// Serial-in/parallel-out receiver: gathers WIDTH strobed bits in a latched direction and
// presents the word on a valid/ready port (word is transferred on a cycle with out_valid && out_ready).
module serial_word_collector #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_word_collector_if.slave bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] outdata_q, outdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;

  // Direction comes from the value latched at frame start, never the live input.
  assign shifted = dir_q ? {bus.sin, sreg_q[WIDTH-1:1]}
                         : {sreg_q[WIDTH-2:0], bus.sin};

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    outdata_d = outdata_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    valid_d   = valid_q;
    ovr_d     = bus.clr_ovr ? 1'b0 : ovr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
          dir_d   = bus.dir;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          sreg_d = shifted;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            outdata_d = shifted;
            valid_d   = 1'b1;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (bus.start) begin
            state_d = SHIFT;
            sreg_d  = '0;
            cnt_d   = '0;
            dir_d   = bus.dir;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.start) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      outdata_q <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      outdata_q <= outdata_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.outdata   = outdata_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.bit_cnt   = cnt_q;
  assign bus.overrun   = ovr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: directed frames with literal expectations plus random traffic,
// all compared every cycle against a bit-queue model of the collector.
module tb_serial_word_collector;
  localparam int W  = 16;
  localparam int CW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] dbg_state;

  serial_word_collector_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  serial_word_collector #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for start, 1 collecting bits, 2 word waiting for consumer
  int         m_mode  = 0;
  bit         m_bits[$];
  bit         m_dir   = 1'b0;
  logic [W-1:0] m_out = '0;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] assemble(input bit q[$], input bit lsb_first);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb_first) w[i] = q[i];
      else           w[W-1-i] = q[i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_bits.delete(); m_dir = 0; m_out = '0; m_valid = 0; m_ovr = 0;
    end else begin
      bit ovr_next;
      ovr_next = m_ovr && !bus.clr_ovr;
      case (m_mode)
        0: if (bus.start) begin m_mode = 1; m_bits.delete(); m_dir = bus.dir; end
        1: if (bus.en) begin
             m_bits.push_back(bus.sin);
             if (m_bits.size() == W) begin
               m_out = assemble(m_bits, m_dir);
               m_valid = 1; m_mode = 2; m_bits.delete();
             end
           end
        default: begin
          if (bus.out_ready) begin
            m_valid = 0;
            if (bus.start) begin m_mode = 1; m_bits.delete(); m_dir = bus.dir; end
            else m_mode = 0;
          end else if (bus.start) begin
            ovr_next = 1;
          end
        end
      endcase
      m_ovr = ovr_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk("outdata",   bus.outdata,   m_out);
      chk("out_valid", bus.out_valid, m_valid);
      chk("busy",      bus.busy,      (m_mode == 1));
      chk("bit_cnt",   bus.bit_cnt,   m_bits.size());
      chk("overrun",   bus.overrun,   m_ovr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.dir = 0; bus.en = 0; bus.sin = 0; bus.out_ready = 0; bus.clr_ovr = 0;
  endtask

  task automatic start_frame(input bit d);
    bus.start = 1; bus.dir = d;
    bus.en = 1; bus.sin = 1'($urandom);
    step();
    bus.start = 0; bus.en = 0;
  endtask

  // Sends bits [from, to) of word in order d; stall_a/stall_b are bit counts after which en idles 3 cycles.
  task automatic send_bits(input logic [W-1:0] word, input bit d, input int from, input int to,
                           input int stall_a, input int stall_b);
    for (int i = from; i < to; i++) begin
      bus.en = 1;
      bus.sin = d ? word[i] : word[W-1-i];
      step();
      bus.en = 0;
      if (i + 1 == stall_a || i + 1 == stall_b) begin
        for (int s = 0; s < 3; s++) begin
          bus.sin = 1'($urandom);
          step();
          chk("stall_busy", bus.busy, 1'b1);
          chk("stall_cnt", bus.bit_cnt, CW'(i + 1));
        end
      end
    end
  endtask

  task automatic pop_expect(input logic [W-1:0] got);
    logic [W-1:0] e;
    if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
    else begin e = exp_q.pop_front(); chk("word", got, e); end
  endtask

  initial begin
    idle_inputs();
    #3 rst_n = 0;
    #1;
    chk("rst_outdata", bus.outdata, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.bit_cnt, 0);
    chk("rst_ovr", bus.overrun, 0);
    #12 rst_n = 1;
    step();
    checking = 1;

    // MSB-first, consumer always ready
    exp_q.push_back(16'hA5C3);
    bus.out_ready = 1;
    start_frame(0);
    send_bits(16'hA5C3, 0, 0, W, -1, -1);
    chk("msb_valid", bus.out_valid, 1);
    pop_expect(bus.outdata);
    step();
    chk("msb_pulse", bus.out_valid, 0);
    chk("msb_idle", bus.busy, 0);
    chk("msb_keep", bus.outdata, 16'hA5C3);

    // LSB-first with stalls
    exp_q.push_back(16'h1234);
    bus.out_ready = 0;
    start_frame(1);
    send_bits(16'h1234, 1, 0, W, 4, 11);
    pop_expect(bus.outdata);
    bus.out_ready = 1; step(); bus.out_ready = 0;

    // Backpressure, overrun, set-beats-clear, then clear
    exp_q.push_back(16'hFFFF);
    start_frame(0);
    send_bits(16'hFFFF, 0, 0, W, -1, -1);
    bus.start = 1; step(); bus.start = 0;
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_ovr", bus.overrun, 1);
    pop_expect(bus.outdata);
    bus.start = 1; bus.clr_ovr = 1; step(); bus.start = 0; bus.clr_ovr = 0;
    chk("ovr_set_wins", bus.overrun, 1);
    bus.out_ready = 1; step(); bus.out_ready = 0;
    chk("bp_release", bus.out_valid, 0);
    chk("ovr_sticky", bus.overrun, 1);
    bus.clr_ovr = 1; step(); bus.clr_ovr = 0;
    chk("ovr_clear", bus.overrun, 0);

    // Back-to-back frames through the HOLD handshake
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h7FFE);
    start_frame(0);
    send_bits(16'h8001, 0, 0, W, -1, -1);
    pop_expect(bus.outdata);
    bus.out_ready = 1; bus.start = 1; bus.dir = 0; step();
    bus.out_ready = 0; bus.start = 0;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_valid", bus.out_valid, 0);
    send_bits(16'h7FFE, 0, 0, W, -1, -1);
    pop_expect(bus.outdata);
    chk("b2b_ovr", bus.overrun, 0);
    bus.out_ready = 1; step(); bus.out_ready = 0;

    // Asynchronous reset mid-frame
    start_frame(1);
    send_bits(16'hDEAD, 1, 0, 9, -1, -1);
    #2 rst_n = 0;
    #1;
    chk("arst_outdata", bus.outdata, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_cnt", bus.bit_cnt, 0);
    chk("arst_valid", bus.out_valid, 0);
    @(posedge clk); #3 rst_n = 1;
    step();
    exp_q.push_back(16'h0F0F);
    start_frame(0);
    send_bits(16'h0F0F, 0, 0, W, -1, -1);
    pop_expect(bus.outdata);
    bus.out_ready = 1; step(); bus.out_ready = 0;

    // dir toggled mid-frame must not matter
    exp_q.push_back(16'hC001);
    start_frame(0);
    send_bits(16'hC001, 0, 0, 5, -1, -1);
    bus.dir = 1;
    send_bits(16'hC001, 0, 5, W, -1, -1);
    pop_expect(bus.outdata);
    bus.out_ready = 1; step(); bus.out_ready = 0; bus.dir = 0;

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.dir       = 1'($urandom);
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.sin       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      bus.clr_ovr   = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();
    step();
    checking = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
